// File: rtl/dfilter_ctrl_if.sv
// dfilter_ctrl_if
//   Register bus between a host and dfilter_ctrl.
//   sel    strobe, one cycle per access
//   we     1=write, 0=read (qualified by sel)
//   addr   word address (3 bits)
//   wdata  write data (32 bits)
//   rdata  registered read data, valid the cycle after a read strobe
interface dfilter_ctrl_if;
   logic        sel;
   logic        we;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output sel, we, addr, wdata, input rdata);
   modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/dfilter_ctrl.sv
// dfilter_ctrl
//   Register-mapped controller for a bank of NCH dfilter channels.
//   Generates the shared refclk sampling tick from an 8-bit prescaler, drives
//   per-channel polarity and rise/fall thresholds, captures edge pulses into
//   W1C pending bits and raises a registered level interrupt.
//   Optional feature macro: DFILTER_CTRL_EVCNT_EN (per-channel 8-bit
//   saturating event counters at address 7).
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   bus              register bus (dfilter_ctrl_if slave)
//   refclk_o         one-clk sampling tick
//   pol_o            per-channel polarity (1=high active)
//   flt_rise_st_o    packed rise thresholds, ch0 in LSBs
//   flt_fall_st_o    packed fall thresholds, ch0 in LSBs
//   data_out_i       filtered levels from the dfilters
//   act_edge_i       one-clk active-edge pulses
//   inact_edge_i     one-clk inactive-edge pulses
//   irq_o            level interrupt, registered
module dfilter_ctrl #(
   parameter int NCH = 4,
   parameter int BW  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   dfilter_ctrl_if.slave       bus,
   output logic                refclk_o,
   output logic [NCH-1:0]      pol_o,
   output logic [NCH*BW-1:0]   flt_rise_st_o,
   output logic [NCH*BW-1:0]   flt_fall_st_o,
   input  logic [NCH-1:0]      data_out_i,
   input  logic [NCH-1:0]      act_edge_i,
   input  logic [NCH-1:0]      inact_edge_i,
   output logic                irq_o
);

   localparam logic [2:0] A_CTRL  = 3'd0;
   localparam logic [2:0] A_POL   = 3'd1;
   localparam logic [2:0] A_RISE  = 3'd2;
   localparam logic [2:0] A_FALL  = 3'd3;
   localparam logic [2:0] A_STAT  = 3'd4;
   localparam logic [2:0] A_PEND  = 3'd5;
   localparam logic [2:0] A_IEN   = 3'd6;
   localparam logic [2:0] A_EVCNT = 3'd7;

   localparam logic [BW-1:0]     THR_RST  = BW'(8'h08);
   localparam logic [NCH*BW-1:0] THRS_RST = {NCH{THR_RST}};

   logic [NCH-1:0]    ch_en_q, ch_en_d;
   logic [7:0]        psc_q, psc_d;
   logic              gen_q, gen_d;
   logic [NCH-1:0]    pol_q, pol_d;
   logic [NCH*BW-1:0] rise_q, rise_d;
   logic [NCH*BW-1:0] fall_q, fall_d;
   logic [NCH-1:0]    pend_act_q, pend_act_d;
   logic [NCH-1:0]    pend_inact_q, pend_inact_d;
   logic [NCH-1:0]    ien_act_q, ien_act_d;
   logic [NCH-1:0]    ien_inact_q, ien_inact_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              irq_q, irq_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       rd_mux;

   logic              wr, rd;
   logic              wr_ctrl, wr_pol, wr_rise, wr_fall, wr_pend, wr_ien;
   logic [NCH-1:0]    set_act, set_inact;
   logic [NCH-1:0]    clr_act, clr_inact;
   logic              unused_wdata;

   assign wr      = bus.sel & bus.we;
   assign rd      = bus.sel & ~bus.we;
   assign wr_ctrl = wr && (bus.addr == A_CTRL);
   assign wr_pol  = wr && (bus.addr == A_POL);
   assign wr_rise = wr && (bus.addr == A_RISE);
   assign wr_fall = wr && (bus.addr == A_FALL);
   assign wr_pend = wr && (bus.addr == A_PEND);
   assign wr_ien  = wr && (bus.addr == A_IEN);

   // Pulses on disabled channels are dropped outright, not deferred.
   assign set_act   = act_edge_i   & ch_en_q & {NCH{gen_q}};
   assign set_inact = inact_edge_i & ch_en_q & {NCH{gen_q}};
   assign clr_act   = {NCH{wr_pend}} & bus.wdata[NCH-1:0];
   assign clr_inact = {NCH{wr_pend}} & bus.wdata[16 +: NCH];

   assign unused_wdata = ^bus.wdata;

`ifdef DFILTER_CTRL_EVCNT_EN
   logic [NCH*8-1:0] evcnt_q;
   logic             wr_evc;

   assign wr_evc = wr && (bus.addr == A_EVCNT);

   // Clear beats a same-cycle increment; counters saturate at 8'hFF.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evcnt_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (wr_evc)
               evcnt_q[i*8 +: 8] <= 8'h00;
            else if ((set_act[i] | set_inact[i]) && (evcnt_q[i*8 +: 8] != 8'hFF))
               evcnt_q[i*8 +: 8] <= evcnt_q[i*8 +: 8] + 8'd1;
         end
      end
   end
`endif

   always_comb begin
      rd_mux = '0;
      case (bus.addr)
         A_CTRL: begin
            rd_mux[NCH-1:0] = ch_en_q;
            rd_mux[15:8]    = psc_q;
            rd_mux[31]      = gen_q;
         end
         A_POL:  rd_mux[NCH-1:0]    = pol_q;
         A_RISE: rd_mux[NCH*BW-1:0] = rise_q;
         A_FALL: rd_mux[NCH*BW-1:0] = fall_q;
         A_STAT: rd_mux[NCH-1:0]    = data_out_i;
         A_PEND: begin
            rd_mux[NCH-1:0]  = pend_act_q;
            rd_mux[16 +: NCH] = pend_inact_q;
         end
         A_IEN: begin
            rd_mux[NCH-1:0]  = ien_act_q;
            rd_mux[16 +: NCH] = ien_inact_q;
         end
         A_EVCNT: begin
`ifdef DFILTER_CTRL_EVCNT_EN
            rd_mux[NCH*8-1:0] = evcnt_q;
`else
            rd_mux = '0;
`endif
         end
         default: rd_mux = '0;
      endcase
   end

   always_comb begin
      ch_en_d = wr_ctrl ? bus.wdata[NCH-1:0] : ch_en_q;
      psc_d   = wr_ctrl ? bus.wdata[15:8]    : psc_q;
      gen_d   = wr_ctrl ? bus.wdata[31]      : gen_q;
      pol_d   = wr_pol  ? bus.wdata[NCH-1:0] : pol_q;
      rise_d  = wr_rise ? bus.wdata[NCH*BW-1:0] : rise_q;
      fall_d  = wr_fall ? bus.wdata[NCH*BW-1:0] : fall_q;
      ien_act_d   = wr_ien ? bus.wdata[NCH-1:0]  : ien_act_q;
      ien_inact_d = wr_ien ? bus.wdata[16 +: NCH] : ien_inact_q;

      // Set is ORed in after the clear so a same-cycle event survives W1C.
      pend_act_d   = (pend_act_q   & ~clr_act)   | set_act;
      pend_inact_d = (pend_inact_q & ~clr_inact) | set_inact;

      // Any CTRL write restarts the prescaler phase.
      if (wr_ctrl || !gen_q || (cnt_q == psc_q))
         cnt_d = 8'd0;
      else
         cnt_d = cnt_q + 8'd1;

      irq_d   = |((pend_act_q & ien_act_q) | (pend_inact_q & ien_inact_q));
      rdata_d = rd ? rd_mux : rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_en_q      <= '0;
         psc_q        <= 8'd2;
         gen_q        <= 1'b0;
         pol_q        <= '1;
         rise_q       <= THRS_RST;
         fall_q       <= THRS_RST;
         pend_act_q   <= '0;
         pend_inact_q <= '0;
         ien_act_q    <= '0;
         ien_inact_q  <= '0;
         cnt_q        <= 8'd0;
         irq_q        <= 1'b0;
         rdata_q      <= '0;
      end else begin
         ch_en_q      <= ch_en_d;
         psc_q        <= psc_d;
         gen_q        <= gen_d;
         pol_q        <= pol_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         pend_act_q   <= pend_act_d;
         pend_inact_q <= pend_inact_d;
         ien_act_q    <= ien_act_d;
         ien_inact_q  <= ien_inact_d;
         cnt_q        <= cnt_d;
         irq_q        <= irq_d;
         rdata_q      <= rdata_d;
      end
   end

   // Tick is decoded from registered state only, so it is clean and is held
   // low whenever gen=0 (count is pinned at 0 and the gen term masks it).
   assign refclk_o      = gen_q && (cnt_q == psc_q);
   assign pol_o         = pol_q;
   assign flt_rise_st_o = rise_q;
   assign flt_fall_st_o = fall_q;
   assign irq_o         = irq_q;
   assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_dfilter_ctrl.sv
module tb_dfilter_ctrl;
   localparam int NCH = 4;
   localparam int BW  = 8;

   logic            clk;
   logic            rst_n;
   logic            refclk;
   logic [NCH-1:0]  pol;
   logic [NCH*BW-1:0] rise_st, fall_st;
   logic [NCH-1:0]  data_out, act_edge, inact_edge;
   logic            irq;

   int checks;
   int errors;

   dfilter_ctrl_if bus_if ();

   dfilter_ctrl #(.NCH(NCH), .BW(BW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus_if.slave),
      .refclk_o      (refclk),
      .pol_o         (pol),
      .flt_rise_st_o (rise_st),
      .flt_fall_st_o (fall_st),
      .data_out_i    (data_out),
      .act_edge_i    (act_edge),
      .inact_edge_i  (inact_edge),
      .irq_o         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_if.sel = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.wdata = d;
      @(posedge clk); #1;
      bus_if.sel = 1'b0; bus_if.we = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      bus_if.sel = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
      @(posedge clk); #1;
      bus_if.sel = 1'b0;
      d = bus_if.rdata;
   endtask

   task automatic pulse(input logic [NCH-1:0] act, input logic [NCH-1:0] inact);
      @(negedge clk);
      act_edge = act; inact_edge = inact;
      @(posedge clk); #1;
      act_edge = '0; inact_edge = '0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic test_reset;
      logic [31:0] d;
      #1;
      checks++; if (refclk !== 1'b0) begin errors++; $display("FAIL reset_refclk: got %0b expected 0", refclk); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", irq); end
      checks++; if (bus_if.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got 0x%08h expected 0", bus_if.rdata); end
      checks++; if (pol !== 4'hF) begin errors++; $display("FAIL reset_pol_o: got 0x%0h expected 0xF", pol); end
      checks++; if (rise_st !== 32'h0808_0808) begin errors++; $display("FAIL reset_rise_o: got 0x%08h expected 0x08080808", rise_st); end
      bus_read(3'd0, d); chk("reset_ctrl", d, 32'h0000_0200);
      bus_read(3'd1, d); chk("reset_pol", d, 32'h0000_000F);
      bus_read(3'd2, d); chk("reset_rise", d, 32'h0808_0808);
      bus_read(3'd3, d); chk("reset_fall", d, 32'h0808_0808);
      bus_read(3'd5, d); chk("reset_pend", d, 32'h0);
      bus_read(3'd6, d); chk("reset_ien", d, 32'h0);
      // gen=0: no ticks at all
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++; if (refclk !== 1'b0) begin errors++; $display("FAIL gen0_refclk: got %0b expected 0 (cycle %0d)", refclk, i); end
      end
   endtask

   task automatic test_prescaler;
      logic exp_tick;
      bus_write(3'd0, 32'h8000_0201);
      // Count is 0 right after the write edge; tick when count reaches 2.
      for (int k = 0; k < 9; k++) begin
         exp_tick = ((k % 3) == 2);
         checks++;
         if (refclk !== exp_tick) begin errors++; $display("FAIL psc2_refclk k=%0d: got %0b expected %0b", k, refclk, exp_tick); end
         @(posedge clk); #1;
      end
      bus_write(3'd0, 32'h8000_0001);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (refclk !== 1'b1) begin errors++; $display("FAIL psc0_refclk k=%0d: got %0b expected 1", k, refclk); end
         @(posedge clk); #1;
      end
      bus_write(3'd0, 32'h0000_0201);
      @(posedge clk); #1;
      checks++; if (refclk !== 1'b0) begin errors++; $display("FAIL gen_off_refclk: got %0b expected 0", refclk); end
   endtask

   task automatic test_config;
      logic [31:0] d;
      bus_write(3'd2, 32'h1122_3344);
      chk("rise_out", rise_st, 32'h1122_3344);
      bus_write(3'd3, 32'hA5A5_0F0F);
      chk("fall_out", fall_st, 32'hA5A5_0F0F);
      bus_write(3'd1, 32'hFFFF_FFF5);
      chk("pol_out", {28'h0, pol}, 32'h5);
      bus_read(3'd1, d); chk("pol_read", d, 32'h5);
      data_out = 4'hA;
      bus_read(3'd4, d); chk("stat_read", d, 32'hA);
      bus_write(3'd4, 32'hFFFF_FFFF);
      bus_read(3'd4, d); chk("stat_after_write", d, 32'hA);
   endtask

   task automatic test_irq;
      logic [31:0] d;
      bus_write(3'd6, 32'h0000_0001);
      bus_write(3'd0, 32'h8000_0201);
      pulse(4'h1, 4'h0);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency: got %0b expected 0", irq); end
      @(posedge clk); #1;
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %0b expected 1", irq); end
      bus_read(3'd5, d); chk("pend_act0", d, 32'h1);
      bus_write(3'd5, 32'h0000_0000);
      bus_read(3'd5, d); chk("pend_w0_noeffect", d, 32'h1);
      bus_write(3'd5, 32'h0000_0001);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold_on_clear: got %0b expected 1", irq); end
      @(posedge clk); #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %0b expected 0", irq); end
   endtask

   task automatic test_disabled_channel;
      logic [31:0] d;
      bus_write(3'd6, 32'h0003_0003);
      pulse(4'h2, 4'h0);
      @(posedge clk); #1;
      bus_read(3'd5, d); chk("pend_disabled_ch", d, 32'h0);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled_ch: got %0b expected 0", irq); end
      // Re-enabling afterwards must not resurrect the dropped pulse.
      bus_write(3'd0, 32'h8000_0203);
      bus_read(3'd5, d); chk("pend_not_deferred", d, 32'h0);
      pulse(4'h0, 4'h1);
      bus_read(3'd5, d); chk("pend_inact0", d, 32'h0001_0000);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_inact: got %0b expected 1", irq); end
      bus_write(3'd5, 32'h0001_0000);
      bus_read(3'd5, d); chk("pend_inact_clr", d, 32'h0);
   endtask

   task automatic test_back_to_back;
      logic [31:0] d;
      pulse(4'h1, 4'h0);
      @(negedge clk);
      act_edge = 4'h1;
      bus_if.sel = 1'b1; bus_if.we = 1'b1; bus_if.addr = 3'd5; bus_if.wdata = 32'h1;
      @(posedge clk); #1;
      act_edge = '0; bus_if.sel = 1'b0; bus_if.we = 1'b0;
      bus_read(3'd5, d); chk("set_wins", d, 32'h1);
      bus_write(3'd5, 32'h0001_000F);
      bus_read(3'd5, d); chk("pend_clear_all", d, 32'h0);
   endtask

   task automatic test_evcnt;
      logic [31:0] d;
`ifdef DFILTER_CTRL_EVCNT_EN
      bus_write(3'd0, 32'h8000_0204);
      bus_write(3'd7, 32'h0);
      bus_read(3'd7, d); chk("evcnt_clear0", d, 32'h0);
      for (int i = 0; i < 3; i++) pulse(4'h4, 4'h0);
      for (int i = 0; i < 2; i++) pulse(4'h0, 4'h4);
      pulse(4'h1, 4'h0);
      bus_read(3'd7, d); chk("evcnt_5", d, 32'h0005_0000);
      @(negedge clk);
      act_edge = 4'h4;
      repeat (295) @(posedge clk);
      #1; act_edge = '0;
      bus_read(3'd7, d); chk("evcnt_sat", d, 32'h00FF_0000);
      bus_write(3'd7, 32'h0);
      bus_read(3'd7, d); chk("evcnt_cleared", d, 32'h0);
      @(negedge clk);
      act_edge = 4'h4;
      bus_if.sel = 1'b1; bus_if.we = 1'b1; bus_if.addr = 3'd7; bus_if.wdata = 32'h0;
      @(posedge clk); #1;
      act_edge = '0; bus_if.sel = 1'b0; bus_if.we = 1'b0;
      bus_read(3'd7, d); chk("evcnt_clr_wins", d, 32'h0);
`else
      bus_write(3'd0, 32'h8000_0204);
      pulse(4'h4, 4'h0);
      bus_write(3'd7, 32'hFFFF_FFFF);
      bus_read(3'd7, d); chk("evcnt_absent", d, 32'h0);
`endif
      bus_write(3'd5, 32'h000F_000F);
   endtask

   task automatic test_async_reset;
      logic [31:0] d;
      bus_write(3'd2, 32'h1122_3344);
      bus_write(3'd0, 32'h8000_0001);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_rise_out", rise_st, 32'h0808_0808);
      checks++; if (refclk !== 1'b0) begin errors++; $display("FAIL arst_refclk: got %0b expected 0", refclk); end
      @(negedge clk);
      rst_n = 1'b1;
      bus_read(3'd0, d); chk("arst_ctrl", d, 32'h0000_0200);
   endtask

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0;
      bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
      data_out = '0; act_edge = '0; inact_edge = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_prescaler();
      test_config();
      test_irq();
      test_disabled_channel();
      test_back_to_back();
      test_evcnt();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
